spider_pixel_reader: RTL
========================

// Module: spider_pixel_reader
// PURPOSE
//  Read side of the spider position/alive bus. Snapshots spider positions once per frame.
//  Resolves, per VGA pixel, which spider sprite covers it and drives the sprite ROM address.
//  Accumulates bullet/spider pixel overlaps during the frame and issues per-spider kill pulses
//  at the next frame boundary. Sits between the spider motion controller and the VGA mixer.
// PARAMETERS
//  N_SPIDER   4    number of spiders (index width fixed at 2 bits)
//  SPR_W      32   sprite width in pixels (power of 2)
//  SPR_H      32   sprite height in pixels (power of 2)
// PORTS
//  clk25          in   1    25 MHz pixel clock
//  reset_n        in   1    synchronous reset, active-low
//  frame_start    in   1    1-cycle pulse, first clock of each frame (before pixel 0,0)
//  pixel_x        in   10   current pixel column
//  pixel_y        in   10   current pixel row
//  video_on       in   1    pixel is in the visible area
//  bullet_pix     in   1    bullet drawn at (pixel_x,pixel_y) this cycle
//  spider_x_bus   in   40   {x3,x2,x1,x0}, 10 bits each, sprite top-left
//  spider_y_bus   in   40   {y3,y2,y1,y0}
//  spider_alive   in   4    alive flag per spider
//  spr_valid      out  1    a live spider covers the pixel (aligned with spr_addr)
//  spr_idx        out  2    index of the covering spider
//  spr_addr       out  10   sprite ROM address {row[4:0],col[4:0]}
//  hit_mask       out  4    spiders hit so far in the current frame (sticky)
//  kill_pulse     out  4    1-cycle pulse, spiders hit in the previous frame
// BEHAVIOUR
//  Reset (reset_n=0 at a clk25 edge): all outputs 0, shadow regs 0, state WAIT_FRAME.
//  FSM: WAIT_FRAME -> ACTIVE on the first frame_start. In WAIT_FRAME: spr_valid=0 and
//   bullet_pix is ignored. ACTIVE persists until reset.
//  Snapshot: on frame_start, latch all spider_x/y/alive into shadow regs. Compares use
//   the shadow regs only; bus changes mid-frame do not affect the current frame.
//  Pipeline, 2-cycle latency. S1 registers pixel_x, pixel_y, video_on and bullet_pix.
//   S2 computes the per-spider cover test and registers the outputs.
//  Cover test per spider i: alive_i AND video_on AND
//   x_i <= px < x_i+SPR_W AND y_i <= py < y_i+SPR_H.
//   Sums are computed at 11 bits, so no wrap at x=1023.
//  Priority: the lowest index wins on overlap. spr_idx is that index.
//   spr_addr = {py-y_i, px-x_i}, low 5 bits each. spr_idx=0 and spr_addr=0 when spr_valid=0.
//  Collision: when the registered bullet_pix=1 and the cover test for spider i is true,
//   hit_mask[i] is set the next cycle. All covering spiders are set, not only the
//   priority winner.
//  Frame boundary, on frame_start in ACTIVE:
//   kill_pulse <= hit_mask, high for exactly 1 cycle.
//   hit_mask <= 0.
//   A hit resolved in that same cycle belongs to the new frame: it sets hit_mask after the
//   clear and is not in this kill_pulse.
//  The first frame_start out of WAIT_FRAME gives kill_pulse=0.
//  Pixels still in flight in S1/S2 at frame_start are compared against the new shadow
//   values. This is harmless because frame_start lands in blanking.
//  Reset mid-frame: pipeline, hit_mask and kill_pulse cleared next edge; back to WAIT_FRAME.
// TESTING
//  1) Reset, frame_start, spider0 at (128,0) alive; pixel (130,5) video_on=1.
//     -> 2 cycles later spr_valid=1, spr_idx=0, spr_addr={5'd5,5'd2}.
//  2) Right/bottom edges: spider at (608,448); pixel (639,479) -> valid, addr=10'h3FF.
//     Pixel (640,448) and pixel (607,448) -> spr_valid=0.
//  3) Spiders 1 and 2 both at (288,100); pixel (290,110) -> spr_idx=1.
//     With bullet_pix=1 there -> hit_mask=4'b0110.
//  4) Bullet on spider3 in frame N -> hit_mask[3]=1.
//     Next frame_start -> kill_pulse=4'b1000 for 1 cycle, then hit_mask=0.
//  5) Change spider_x_bus mid-frame -> rendering is unchanged until the next frame_start.
//     A dead spider (alive=0) never gives spr_valid and never sets hit_mask.
//  6) Assert reset_n=0 mid-frame with hit_mask=4'b0011 -> next edge all outputs 0.
//     A frame_start before the first post-reset frame_start is impossible by definition;
//     the first frame_start after reset gives kill_pulse=0.

Source files
------------

// File: rtl/spider_pixel_reader.sv
// Read side of the spider position bus: per-frame snapshot, per-pixel sprite
// resolution with a 2-stage pipeline, and bullet-hit accumulation with kill pulses.
module spider_pixel_reader #(
  parameter int N_SPIDER = 4,
  parameter int SPR_W    = 32,
  parameter int SPR_H    = 32
) (
  input  logic                      i_clk25,
  input  logic                      i_reset_n,
  input  logic                      i_frame_start,
  input  logic [9:0]                i_pixel_x,
  input  logic [9:0]                i_pixel_y,
  input  logic                      i_video_on,
  input  logic                      i_bullet_pix,
  input  logic [10*N_SPIDER-1:0]    i_spider_x_bus,
  input  logic [10*N_SPIDER-1:0]    i_spider_y_bus,
  input  logic [N_SPIDER-1:0]       i_spider_alive,
  output logic                      o_spr_valid,
  output logic [1:0]                o_spr_idx,
  output logic [$clog2(SPR_H)+$clog2(SPR_W)-1:0] o_spr_addr,
  output logic [N_SPIDER-1:0]       o_hit_mask,
  output logic [N_SPIDER-1:0]       o_kill_pulse
);

  localparam int CW = $clog2(SPR_W);
  localparam int RW = $clog2(SPR_H);

  typedef enum logic {
    WAIT_FRAME = 1'b0,
    ACTIVE     = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_active;

  logic [9:0]          r_sx [N_SPIDER];
  logic [9:0]          r_sy [N_SPIDER];
  logic [N_SPIDER-1:0] r_salive;

  logic [9:0] r_s1_px;
  logic [9:0] r_s1_py;
  logic       r_s1_von;
  logic       r_s1_bul;

  logic [N_SPIDER-1:0] w_cover;
  logic [N_SPIDER-1:0] w_hits;
  logic [9:0]          w_dx [N_SPIDER];
  logic [9:0]          w_dy [N_SPIDER];
  logic                w_valid;
  logic [1:0]          w_idx;
  logic [RW+CW-1:0]    w_addr;

  always_ff @(posedge i_clk25) begin
    if (!i_reset_n) r_state <= WAIT_FRAME;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_active    = (r_state == ACTIVE);
    if (r_state == WAIT_FRAME && i_frame_start) w_state_nxt = ACTIVE;
  end

  // Shadow copy of the bus, stable for the whole frame
  always_ff @(posedge i_clk25) begin
    if (!i_reset_n) begin
      for (int i = 0; i < N_SPIDER; i++) begin
        r_sx[i] <= '0;
        r_sy[i] <= '0;
      end
      r_salive <= '0;
    end else if (i_frame_start) begin
      for (int i = 0; i < N_SPIDER; i++) begin
        r_sx[i] <= i_spider_x_bus[10*i +: 10];
        r_sy[i] <= i_spider_y_bus[10*i +: 10];
      end
      r_salive <= i_spider_alive;
    end
  end

  always_ff @(posedge i_clk25) begin
    if (!i_reset_n) begin
      r_s1_px  <= '0;
      r_s1_py  <= '0;
      r_s1_von <= 1'b0;
      r_s1_bul <= 1'b0;
    end else begin
      r_s1_px  <= i_pixel_x;
      r_s1_py  <= i_pixel_y;
      r_s1_von <= i_video_on;
      r_s1_bul <= i_bullet_pix;
    end
  end

  // 11-bit bounds so a sprite near x=1023 does not wrap
  always_comb begin
    w_cover = '0;
    for (int i = 0; i < N_SPIDER; i++) begin
      w_dx[i]    = r_s1_px - r_sx[i];
      w_dy[i]    = r_s1_py - r_sy[i];
      w_cover[i] = w_active && r_s1_von && r_salive[i]
                && ({1'b0, r_s1_px} >= {1'b0, r_sx[i]})
                && ({1'b0, r_s1_px} <  ({1'b0, r_sx[i]} + 11'(SPR_W)))
                && ({1'b0, r_s1_py} >= {1'b0, r_sy[i]})
                && ({1'b0, r_s1_py} <  ({1'b0, r_sy[i]} + 11'(SPR_H)));
    end
    w_hits = w_cover & {N_SPIDER{r_s1_bul}};
  end

  // Walk from the top index down so the lowest covering index wins
  always_comb begin
    w_valid = 1'b0;
    w_idx   = '0;
    w_addr  = '0;
    for (int i = N_SPIDER - 1; i >= 0; i--) begin
      if (w_cover[i]) begin
        w_valid = 1'b1;
        w_idx   = 2'(i);
        w_addr  = {w_dy[i][RW-1:0], w_dx[i][CW-1:0]};
      end
    end
  end

  always_ff @(posedge i_clk25) begin
    if (!i_reset_n) begin
      o_spr_valid <= 1'b0;
      o_spr_idx   <= '0;
      o_spr_addr  <= '0;
    end else begin
      o_spr_valid <= w_valid;
      o_spr_idx   <= w_idx;
      o_spr_addr  <= w_addr;
    end
  end

  // A hit landing on the frame boundary counts toward the new frame
  always_ff @(posedge i_clk25) begin
    if (!i_reset_n) begin
      o_hit_mask   <= '0;
      o_kill_pulse <= '0;
    end else if (i_frame_start && w_active) begin
      o_kill_pulse <= o_hit_mask;
      o_hit_mask   <= w_hits;
    end else begin
      o_kill_pulse <= '0;
      o_hit_mask   <= o_hit_mask | w_hits;
    end
  end

endmodule
